// File: rtl/ex_mem_stage.sv
// Ex/Mem pipeline register with the Mem-stage data memory and redirect logic.
// Optional macro MEM_ALIGN_CHECK_EN: flags and suppresses misaligned word accesses.
module ex_mem_stage #(
    parameter int MEM_AW    = 10,
    parameter int MEM_DEPTH = 2 ** MEM_AW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] ALU_ans_Ex,
    input  logic [31:0] busB_out_Ex,
    input  logic [31:0] B_Addr_Ex,
    input  logic [31:0] J_Addr_Ex,
    input  logic [31:0] PC_Addr_Ex,
    input  logic [4:0]  Reg_Target_Ex,
    input  logic        ZF_Ex,
    input  logic        OF_Ex,
    input  logic        Sign_Ex,
    input  logic        Branch_Ex,
    input  logic        Jump_Ex,
    input  logic        Jal_Ex,
    input  logic        Rtype_J_Ex,
    input  logic        MemToReg_Ex,
    input  logic        RegWr_Ex,
    input  logic        MemWr_Ex,
    input  logic        WrByte_Ex,
    input  logic [1:0]  LoadByte_Ex,
    output logic [31:0] ALU_ans_Mem,
    output logic [31:0] Mem_Data_Mem,
    output logic [31:0] Link_Mem,
    output logic [4:0]  Reg_Target_Mem,
    output logic        RegWr_Mem,
    output logic        MemToReg_Mem,
    output logic        Jal_Mem,
    output logic [1:0]  PCSrc_Mem,
    output logic [31:0] Target_Mem,
    output logic        Redirect_Mem,
    output logic        Addr_Err
);

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] busb;
        logic [31:0] baddr;
        logic [31:0] jaddr;
        logic [31:0] pc;
        logic [4:0]  rt;
        logic        zf;
        logic        of;
        logic        sign;
        logic        branch;
        logic        jump;
        logic        jal;
        logic        rtype_j;
        logic        memtoreg;
        logic        regwr;
        logic        memwr;
        logic        wrbyte;
        logic [1:0]  lb;
    } exmem_t;

    exmem_t ex_d, ex_q;

    logic [31:0]       mem_q [MEM_DEPTH];
    logic [MEM_AW-1:0] idx;
    logic [1:0]        lane;
    logic [31:0]       rdata;
    logic [7:0]        rbyte;
    logic              we;
    logic              unused_ok;

    // Next-state of the pipeline register: reset/flush bubble, stall hold, else capture.
    always_comb begin
        ex_d = ex_q;
        if (rst || flush) begin
            ex_d = '0;
        end else if (!stall) begin
            ex_d.alu      = ALU_ans_Ex;
            ex_d.busb     = busB_out_Ex;
            ex_d.baddr    = B_Addr_Ex;
            ex_d.jaddr    = J_Addr_Ex;
            ex_d.pc       = PC_Addr_Ex;
            ex_d.rt       = Reg_Target_Ex;
            ex_d.zf       = ZF_Ex;
            ex_d.of       = OF_Ex;
            ex_d.sign     = Sign_Ex;
            ex_d.branch   = Branch_Ex;
            ex_d.jump     = Jump_Ex;
            ex_d.jal      = Jal_Ex;
            ex_d.rtype_j  = Rtype_J_Ex;
            ex_d.memtoreg = MemToReg_Ex;
            ex_d.regwr    = RegWr_Ex;
            ex_d.memwr    = MemWr_Ex;
            ex_d.wrbyte   = WrByte_Ex;
            ex_d.lb       = LoadByte_Ex;
        end
    end

    // Ex/Mem register.
    always_ff @(posedge clk) begin
        ex_q <= ex_d;
    end

    assign idx  = ex_q.alu[MEM_AW+1:2];
    assign lane = ex_q.alu[1:0];

`ifdef MEM_ALIGN_CHECK_EN
    logic word_acc;
    logic mis_acc;
    logic addr_err_q;

    assign word_acc = (ex_q.memwr & ~ex_q.wrbyte)
                    | (ex_q.memtoreg & (ex_q.lb == 2'b00 || ex_q.lb == 2'b11));
    assign mis_acc  = word_acc && (lane != 2'b00);
    assign we       = ex_q.memwr & ~mis_acc;

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err_q <= 1'b0;
        end else if (mis_acc) begin
            addr_err_q <= 1'b1;
        end
    end

    assign Addr_Err = addr_err_q;
`else
    assign we       = ex_q.memwr;
    assign Addr_Err = 1'b0;
`endif

    // Data memory write at the end of the Mem cycle; byte stores touch one lane.
    always_ff @(posedge clk) begin
        if (!rst && we) begin
            if (ex_q.wrbyte) begin
                unique case (lane)
                    2'd0: mem_q[idx][7:0]   <= ex_q.busb[7:0];
                    2'd1: mem_q[idx][15:8]  <= ex_q.busb[7:0];
                    2'd2: mem_q[idx][23:16] <= ex_q.busb[7:0];
                    default: mem_q[idx][31:24] <= ex_q.busb[7:0];
                endcase
            end else begin
                mem_q[idx] <= ex_q.busb;
            end
        end
    end

    // Asynchronous read with lane select and sign/zero extension.
    always_comb begin
        rdata = mem_q[idx];
        unique case (lane)
            2'd0:    rbyte = rdata[7:0];
            2'd1:    rbyte = rdata[15:8];
            2'd2:    rbyte = rdata[23:16];
            default: rbyte = rdata[31:24];
        endcase
        unique case (ex_q.lb)
            2'b01:   Mem_Data_Mem = {{24{rbyte[7]}}, rbyte};
            2'b10:   Mem_Data_Mem = {24'h0, rbyte};
            default: Mem_Data_Mem = rdata;
        endcase
    end

    // Redirect selection: register jump, then jump/jal, then taken branch.
    always_comb begin
        PCSrc_Mem  = 2'b00;
        Target_Mem = 32'h0;
        if (ex_q.rtype_j) begin
            PCSrc_Mem  = 2'b11;
            Target_Mem = ex_q.alu;
        end else if (ex_q.jump || ex_q.jal) begin
            PCSrc_Mem  = 2'b10;
            Target_Mem = ex_q.jaddr;
        end else if (ex_q.branch && ex_q.zf) begin
            PCSrc_Mem  = 2'b01;
            Target_Mem = ex_q.baddr;
        end
    end

    assign Redirect_Mem   = (PCSrc_Mem != 2'b00);
    assign ALU_ans_Mem    = ex_q.alu;
    assign Link_Mem       = ex_q.pc;
    assign Reg_Target_Mem = ex_q.rt;
    assign RegWr_Mem      = ex_q.regwr & ~ex_q.of;
    assign MemToReg_Mem   = ex_q.memtoreg;
    assign Jal_Mem        = ex_q.jal;

    assign unused_ok = ^{ex_q.sign, ex_q.alu[31:MEM_AW+2]};

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed testbench for ex_mem_stage.
// Build with +define+MEM_ALIGN_CHECK_EN to exercise the alignment check.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [31:0] ALU_ans_Ex, busB_out_Ex, B_Addr_Ex, J_Addr_Ex, PC_Addr_Ex;
    logic [4:0]  Reg_Target_Ex;
    logic        ZF_Ex, OF_Ex, Sign_Ex;
    logic        Branch_Ex, Jump_Ex, Jal_Ex, Rtype_J_Ex;
    logic        MemToReg_Ex, RegWr_Ex, MemWr_Ex, WrByte_Ex;
    logic [1:0]  LoadByte_Ex;
    logic [31:0] ALU_ans_Mem, Mem_Data_Mem, Link_Mem, Target_Mem;
    logic [4:0]  Reg_Target_Mem;
    logic        RegWr_Mem, MemToReg_Mem, Jal_Mem, Redirect_Mem, Addr_Err;
    logic [1:0]  PCSrc_Mem;

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ALU_ans_Ex(ALU_ans_Ex), .busB_out_Ex(busB_out_Ex),
        .B_Addr_Ex(B_Addr_Ex), .J_Addr_Ex(J_Addr_Ex),
        .PC_Addr_Ex(PC_Addr_Ex), .Reg_Target_Ex(Reg_Target_Ex),
        .ZF_Ex(ZF_Ex), .OF_Ex(OF_Ex), .Sign_Ex(Sign_Ex),
        .Branch_Ex(Branch_Ex), .Jump_Ex(Jump_Ex), .Jal_Ex(Jal_Ex),
        .Rtype_J_Ex(Rtype_J_Ex), .MemToReg_Ex(MemToReg_Ex),
        .RegWr_Ex(RegWr_Ex), .MemWr_Ex(MemWr_Ex), .WrByte_Ex(WrByte_Ex),
        .LoadByte_Ex(LoadByte_Ex),
        .ALU_ans_Mem(ALU_ans_Mem), .Mem_Data_Mem(Mem_Data_Mem),
        .Link_Mem(Link_Mem), .Reg_Target_Mem(Reg_Target_Mem),
        .RegWr_Mem(RegWr_Mem), .MemToReg_Mem(MemToReg_Mem),
        .Jal_Mem(Jal_Mem), .PCSrc_Mem(PCSrc_Mem), .Target_Mem(Target_Mem),
        .Redirect_Mem(Redirect_Mem), .Addr_Err(Addr_Err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        ALU_ans_Ex = 0; busB_out_Ex = 0; B_Addr_Ex = 0; J_Addr_Ex = 0;
        PC_Addr_Ex = 0; Reg_Target_Ex = 0; ZF_Ex = 0; OF_Ex = 0; Sign_Ex = 0;
        Branch_Ex = 0; Jump_Ex = 0; Jal_Ex = 0; Rtype_J_Ex = 0;
        MemToReg_Ex = 0; RegWr_Ex = 0; MemWr_Ex = 0; WrByte_Ex = 0;
        LoadByte_Ex = 2'b00;
    endtask

    task automatic rand_in();
        ALU_ans_Ex = $urandom; busB_out_Ex = $urandom; B_Addr_Ex = $urandom;
        J_Addr_Ex = $urandom; PC_Addr_Ex = $urandom;
        Reg_Target_Ex = 5'($urandom); ZF_Ex = 1'($urandom);
        OF_Ex = 1'b0; Sign_Ex = 1'($urandom);
        Branch_Ex = 1'b1; Jump_Ex = 1'b1; Jal_Ex = 1'b1; Rtype_J_Ex = 1'b1;
        MemToReg_Ex = 1'b1; RegWr_Ex = 1'b1; MemWr_Ex = 1'b1;
        WrByte_Ex = 1'($urandom); LoadByte_Ex = 2'($urandom);
    endtask

    // Issue one instruction into Ex and clock it into Mem.
    task automatic issue_store(input logic [31:0] a, input logic [31:0] d,
                               input logic byte_wr);
        nop();
        ALU_ans_Ex = a; busB_out_Ex = d; MemWr_Ex = 1'b1; WrByte_Ex = byte_wr;
        tick();
    endtask

    task automatic issue_load(input logic [31:0] a, input logic [1:0] lb);
        nop();
        ALU_ans_Ex = a; MemToReg_Ex = 1'b1; RegWr_Ex = 1'b1; LoadByte_Ex = lb;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        rand_in(); tick();
        rand_in(); tick();
        vec++;
        if (ALU_ans_Mem !== 0 || Link_Mem !== 0 || Target_Mem !== 0) begin
            err++;
            $display("FAIL reset_data alu=%h link=%h tgt=%h want 0",
                     ALU_ans_Mem, Link_Mem, Target_Mem);
        end
        vec++;
        if ({Reg_Target_Mem, RegWr_Mem, MemToReg_Mem, Jal_Mem} !== 8'h0) begin
            err++;
            $display("FAIL reset_ctrl rt=%h rw=%b m2r=%b jal=%b want 0",
                     Reg_Target_Mem, RegWr_Mem, MemToReg_Mem, Jal_Mem);
        end
        vec++;
        if (PCSrc_Mem !== 2'b00 || Redirect_Mem !== 1'b0 || Addr_Err !== 1'b0) begin
            err++;
            $display("FAIL reset_redir pcsrc=%b redir=%b aerr=%b want 00/0/0",
                     PCSrc_Mem, Redirect_Mem, Addr_Err);
        end
        nop();
        rst = 1'b0;
        // Known contents at 0x30, then a store to it is killed by reset.
        issue_store(32'h30, 32'hCAFE_BABE, 1'b0);
        issue_store(32'h30, 32'h1234_5678, 1'b0);
        nop();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        issue_load(32'h30, 2'b00);
        vec++;
        if (Mem_Data_Mem !== 32'hCAFE_BABE) begin
            err++;
            $display("FAIL reset_nowrite got=%h want=cafebabe", Mem_Data_Mem);
        end
    endtask

    task automatic test_store_load();
        issue_store(32'h10, 32'h8000_00F5, 1'b0);
        issue_load(32'h13, 2'b01);
        vec++;
        if (Mem_Data_Mem !== 32'hFFFF_FF80) begin
            err++;
            $display("FAIL ld_sext got=%h want=ffffff80", Mem_Data_Mem);
        end
        issue_load(32'h13, 2'b10);
        vec++;
        if (Mem_Data_Mem !== 32'h0000_0080) begin
            err++;
            $display("FAIL ld_zext got=%h want=00000080", Mem_Data_Mem);
        end
        issue_load(32'h10, 2'b00);
        vec++;
        if (Mem_Data_Mem !== 32'h8000_00F5 || MemToReg_Mem !== 1'b1) begin
            err++;
            $display("FAIL ld_word got=%h m2r=%b want=800000f5/1",
                     Mem_Data_Mem, MemToReg_Mem);
        end
        issue_load(32'h10, 2'b11);
        vec++;
        if (Mem_Data_Mem !== 32'h8000_00F5) begin
            err++;
            $display("FAIL ld_word11 got=%h want=800000f5", Mem_Data_Mem);
        end
        issue_load(32'h1010, 2'b00);
        vec++;
        if (Mem_Data_Mem !== 32'h8000_00F5) begin
            err++;
            $display("FAIL ld_wrap got=%h want=800000f5", Mem_Data_Mem);
        end
    endtask

    task automatic test_byte_store();
        issue_store(32'h20, 32'h1122_3344, 1'b0);
        issue_store(32'h21, 32'hFFFF_FFAB, 1'b1);
        issue_load(32'h20, 2'b00);
        vec++;
        if (Mem_Data_Mem !== 32'h1122_AB44) begin
            err++;
            $display("FAIL byte_st got=%h want=1122ab44", Mem_Data_Mem);
        end
        issue_load(32'h21, 2'b01);
        vec++;
        if (Mem_Data_Mem !== 32'hFFFF_FFAB) begin
            err++;
            $display("FAIL byte_ld got=%h want=ffffffab", Mem_Data_Mem);
        end
    endtask

    task automatic test_redirect();
        nop();
        Branch_Ex = 1; ZF_Ex = 1; Jump_Ex = 1;
        J_Addr_Ex = 32'h1000; B_Addr_Ex = 32'h2000;
        tick();
        vec++;
        if (PCSrc_Mem !== 2'b10 || Target_Mem !== 32'h1000 || Redirect_Mem !== 1'b1) begin
            err++;
            $display("FAIL redir_jmp pcsrc=%b tgt=%h red=%b want 10/1000/1",
                     PCSrc_Mem, Target_Mem, Redirect_Mem);
        end
        nop();
        Branch_Ex = 1; ZF_Ex = 0; B_Addr_Ex = 32'h2000;
        tick();
        vec++;
        if (PCSrc_Mem !== 2'b00 || Target_Mem !== 0 || Redirect_Mem !== 1'b0) begin
            err++;
            $display("FAIL redir_nt pcsrc=%b tgt=%h red=%b want 00/0/0",
                     PCSrc_Mem, Target_Mem, Redirect_Mem);
        end
        nop();
        Branch_Ex = 1; ZF_Ex = 1; B_Addr_Ex = 32'h2000;
        tick();
        vec++;
        if (PCSrc_Mem !== 2'b01 || Target_Mem !== 32'h2000) begin
            err++;
            $display("FAIL redir_br pcsrc=%b tgt=%h want 01/2000",
                     PCSrc_Mem, Target_Mem);
        end
        nop();
        Rtype_J_Ex = 1; Jump_Ex = 1; ALU_ans_Ex = 32'h40; J_Addr_Ex = 32'h1000;
        tick();
        vec++;
        if (PCSrc_Mem !== 2'b11 || Target_Mem !== 32'h40) begin
            err++;
            $display("FAIL redir_jr pcsrc=%b tgt=%h want 11/40",
                     PCSrc_Mem, Target_Mem);
        end
        nop();
        Jal_Ex = 1; J_Addr_Ex = 32'h3000; PC_Addr_Ex = 32'h204;
        RegWr_Ex = 1; Reg_Target_Ex = 5'd31;
        tick();
        vec++;
        if (PCSrc_Mem !== 2'b10 || Target_Mem !== 32'h3000 ||
            Link_Mem !== 32'h204 || Jal_Mem !== 1'b1 || Reg_Target_Mem !== 5'd31) begin
            err++;
            $display("FAIL redir_jal pcsrc=%b tgt=%h link=%h jal=%b rt=%0d want 10/3000/204/1/31",
                     PCSrc_Mem, Target_Mem, Link_Mem, Jal_Mem, Reg_Target_Mem);
        end
    endtask

    task automatic test_stall_flush();
        nop();
        ALU_ans_Ex = 32'h55; RegWr_Ex = 1; Reg_Target_Ex = 5'd7; PC_Addr_Ex = 32'h104;
        tick();
        nop();
        ALU_ans_Ex = 32'h99; Reg_Target_Ex = 5'd3; PC_Addr_Ex = 32'h200; Jump_Ex = 1;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vec++;
            if (ALU_ans_Mem !== 32'h55 || Reg_Target_Mem !== 5'd7 ||
                Link_Mem !== 32'h104 || RegWr_Mem !== 1'b1 || PCSrc_Mem !== 2'b00) begin
                err++;
                $display("FAIL stall_hold%0d alu=%h rt=%0d link=%h rw=%b pcsrc=%b want 55/7/104/1/00",
                         i, ALU_ans_Mem, Reg_Target_Mem, Link_Mem, RegWr_Mem, PCSrc_Mem);
            end
        end
        nop();
        ALU_ans_Ex = 32'h30; busB_out_Ex = 32'hDEAD_0000; MemWr_Ex = 1; RegWr_Ex = 1;
        stall = 1'b1; flush = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b0;
        vec++;
        if (RegWr_Mem !== 1'b0 || ALU_ans_Mem !== 0) begin
            err++;
            $display("FAIL flush_bubble rw=%b alu=%h want 0/0", RegWr_Mem, ALU_ans_Mem);
        end
        nop();
        tick();
        issue_load(32'h30, 2'b00);
        vec++;
        if (Mem_Data_Mem !== 32'hCAFE_BABE) begin
            err++;
            $display("FAIL flush_nowrite got=%h want=cafebabe", Mem_Data_Mem);
        end
        nop();
        OF_Ex = 1; RegWr_Ex = 1; Reg_Target_Ex = 5'd9; ALU_ans_Ex = 32'h7FFF_FFFF;
        tick();
        vec++;
        if (RegWr_Mem !== 1'b0 || Reg_Target_Mem !== 5'd9) begin
            err++;
            $display("FAIL ovf_kill rw=%b rt=%0d want 0/9", RegWr_Mem, Reg_Target_Mem);
        end
    endtask

    task automatic test_align();
        issue_store(32'h22, 32'h9988_7766, 1'b0);
        issue_load(32'h20, 2'b00);
`ifdef MEM_ALIGN_CHECK_EN
        vec++;
        if (Mem_Data_Mem !== 32'h1122_AB44 || Addr_Err !== 1'b1) begin
            err++;
            $display("FAIL align_block data=%h aerr=%b want 1122ab44/1",
                     Mem_Data_Mem, Addr_Err);
        end
        nop();
        tick(); tick();
        vec++;
        if (Addr_Err !== 1'b1) begin
            err++;
            $display("FAIL align_sticky aerr=%b want 1", Addr_Err);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vec++;
        if (Addr_Err !== 1'b0) begin
            err++;
            $display("FAIL align_clear aerr=%b want 0", Addr_Err);
        end
`else
        vec++;
        if (Mem_Data_Mem !== 32'h9988_7766 || Addr_Err !== 1'b0) begin
            err++;
            $display("FAIL align_off data=%h aerr=%b want 99887766/0",
                     Mem_Data_Mem, Addr_Err);
        end
`endif
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        nop();
        test_reset();
        test_store_load();
        test_byte_store();
        test_redirect();
        test_stall_flush();
        test_align();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Ex/Mem pipeline register plus the Mem-stage datapath; sits directly downstream of the execution unit.
- Latches the Ex-stage results and control at each clock edge.
- Performs the data-memory access: word or byte store, and word or byte load with sign/zero extension.
- Resolves branch and jump redirects, and drives the Mem/Wr-bound values and the Ex/Mem bypass source.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit data-memory words.
- MEM_AW, 10, word-address width; MEM_DEPTH = 2**MEM_AW.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  hold Ex/Mem register contents.
- flush  in  1  load a bubble into Ex/Mem.
- ALU_ans_Ex  in  32  ALU result / memory address.
- busB_out_Ex  in  32  store data (already bypass-resolved).
- B_Addr_Ex  in  32  branch target.
- J_Addr_Ex  in  32  jump target.
- PC_Addr_Ex  in  32  PC+4 of instruction (jal link value).
- Reg_Target_Ex  in  5  destination register.
- ZF_Ex, OF_Ex, Sign_Ex  in  1 each  ALU flags.
- Branch_Ex, Jump_Ex, Jal_Ex, Rtype_J_Ex, MemToReg_Ex, RegWr_Ex, MemWr_Ex, WrByte_Ex  in  1 each  control.
- LoadByte_Ex  in  2  load mode.
- ALU_ans_Mem  out  32  registered ALU result; also the Ex/Mem bypass value.
- Mem_Data_Mem  out  32  extended load data.
- Link_Mem  out  32  registered PC_Addr.
- Reg_Target_Mem  out  5  registered destination.
- RegWr_Mem, MemToReg_Mem, Jal_Mem  out  1 each  registered write-back control.
- PCSrc_Mem  out  2  00 sequential, 01 branch, 10 jump, 11 register jump.
- Target_Mem  out  32  redirect address.
- Redirect_Mem  out  1  PCSrc_Mem != 00; upstream flushes IF/ID/Ex.
- Addr_Err  out  1  misalignment flag (optional feature only; otherwise tied 0).

Behaviour:
- Ex/Mem register update, on each clk edge:
  - Priority: rst > flush > stall > capture.
  - rst or flush: all registered control bits = 0, LoadByte = 00; all data fields = 0.
  - stall: hold every field.
  - Otherwise: capture all *_Ex inputs.
- Latency: values captured at edge N drive the *_Mem outputs during cycle N..N+1. All Mem-stage outputs are combinational from the registered fields.
- Reset values: every output 0. PCSrc_Mem = 00, Redirect_Mem = 0. Mem_Data_Mem = 0 because LoadByte = 00 and the address is 0 … not guaranteed, since memory contents are not reset. Mem_Data_Mem is don't-care while MemToReg_Mem = 0.
- Data memory:
  - Word index = ALU_ans_Mem[MEM_AW+1:2]; bits above the index are ignored, so addresses wrap modulo 4*MEM_DEPTH.
  - Write occurs at the edge ending the Mem cycle when MemWr_Mem = 1 and rst = 0.
  - Byte store (WrByte = 1): write busB[7:0] into lane ALU_ans_Mem[1:0] (lane 0 = bits 7:0). Other lanes are unchanged.
  - Word store (WrByte = 0): write all 32 bits; address bits [1:0] are ignored.
  - Write is not gated by stall: a stalled store writes once, then rewrites the same value (idempotent).
- Read: asynchronous from the registered address. A store at edge N followed by a load of the same address in cycle N+1 returns the new data.
- LoadByte modes:
  - 00: word.
  - 01: lane byte, sign-extended.
  - 10: lane byte, zero-extended.
  - 11: word.
- Redirect, evaluated in priority order:
  - Rtype_J_Mem: 11, target = ALU_ans_Mem.
  - Jump_Mem: 10, target = J_Addr.
  - Branch_Mem & ZF_Mem: 01, target = B_Addr.
  - Otherwise 00, Target_Mem = 0.
  - Jal implies Jump.
- Overflow: OF_Mem = 1 forces RegWr_Mem output to 0. The register content is kept.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A word access (MemWr or MemToReg with LoadByte ∈ {00, 11}) with ALU_ans_Mem[1:0] != 0 suppresses the memory write and sets sticky Addr_Err at that edge.
  - Addr_Err is cleared only by rst.
- Undefined:
  - Low address bits are ignored and the access completes.
  - Addr_Err is constant 0 with no register.

Test Plan:
- Reset: pulse rst for 2 cycles with random inputs -> all outputs 0, PCSrc_Mem = 00; a MemWr asserted during rst does not write (a later word load of that address returns the prior contents).
- Store/load: word store 0x8000_00F5 to address 0x10, then in the next cycle load 0x13 with LoadByte = 01 -> 0xFFFF_FF80; with LoadByte = 10 -> 0x0000_0080; word load of 0x10 -> 0x8000_00F5.
- Byte store: word-store 0x1122_3344 to 0x20, then byte-store 0xAB to 0x21 -> word load of 0x20 returns 0x1122_AB44.
- Redirect priority: Branch = 1 with ZF = 1 and Jump = 1 in the same instruction -> PCSrc_Mem = 10, Target_Mem = J_Addr. Branch with ZF = 0 -> 00, Redirect_Mem = 0. Rtype_J with ALU_ans = 0x40 -> 11, target 0x40.
- Stall/flush: assert stall for 3 cycles -> outputs hold. Assert stall and flush together -> bubble (RegWr_Mem = 0, MemWr not performed). OF = 1 with RegWr = 1 -> RegWr_Mem = 0.
- MEM_ALIGN_CHECK_EN: word store to 0x22 -> memory unchanged, Addr_Err = 1 and remains 1 until rst. Without the macro -> the word at 0x20 is written and Addr_Err = 0.
